// File: rtl/mult_eval_pkg.sv
// rtl/mult_eval_pkg.sv - shared types and size helpers for the multiplier sweep evaluator
package mult_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int pw_of(input int w);
        return 2 * w;
    endfunction

    function automatic int n_of(input int w);
        return 1 << (2 * w);
    endfunction

    localparam int DEF_WIDTH = 2;
    localparam int DEF_PW    = pw_of(DEF_WIDTH);
    localparam int DEF_CW    = 2 * DEF_WIDTH + 1;

    // Statistics snapshot for the default-width configuration.
    typedef struct packed {
        logic [DEF_CW-1:0]              match_count;
        logic [DEF_PW-1:0][DEF_CW-1:0]  bit_err;
        logic                           fail_valid;
        logic [DEF_WIDTH-1:0]           fail_a;
        logic [DEF_WIDTH-1:0]           fail_b;
        logic [DEF_PW-1:0]              fail_p;
    } stat_rec_t;

endpackage

// File: rtl/mult_eval_delay.sv
// rtl/mult_eval_delay.sv - LAT-deep delay line for {valid, a, b, golden}; pass-through at LAT=0
module mult_eval_delay #(
    parameter int LAT = 0,
    parameter int DW  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dout = din;
        end else begin : g_shift
            logic [DW-1:0] sr [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mult_sweep_evaluator.sv
// rtl/mult_sweep_evaluator.sv - exhaustive operand sweep scoring one candidate multiplier
module mult_sweep_evaluator #(
    parameter int WIDTH = 2,
    parameter int LAT   = 0,
    parameter int CW    = 2 * WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [WIDTH-1:0]        cand_a,
    output logic [WIDTH-1:0]        cand_b,
    input  logic [2*WIDTH-1:0]      cand_p,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CW-1:0]           match_count,
    output logic [2*WIDTH*CW-1:0]   bit_err,
    output logic                    fail_valid,
    output logic [WIDTH-1:0]        fail_a,
    output logic [WIDTH-1:0]        fail_b,
    output logic [2*WIDTH-1:0]      fail_p
);
    import mult_eval_pkg::*;

    localparam int PW  = pw_of(WIDTH);
    localparam int N   = n_of(WIDTH);
    localparam int DW  = 1 + 2 * WIDTH + PW;
    localparam int DCW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    state_t          state, next_state;
    logic [PW-1:0]   idx;
    logic [DCW-1:0]  drain_cnt;
    logic            accept;
    logic            last_idx;

    logic            issue_valid;
    logic [PW-1:0]   issue_gold;

    logic [DW-1:0]   d_out;
    logic            d_valid;
    logic [WIDTH-1:0] d_a, d_b;
    logic [PW-1:0]   d_gold;
    logic [PW-1:0]   diff;

    logic [CW-1:0]   be_q [PW];

    assign accept   = start && (state == IDLE || state == DONE);
    assign last_idx = (idx == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE:  if (start) next_state = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (last_idx) next_state = (LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DCW'(LAT - 1)) next_state = DONE;
            end
            DONE:  if (start) next_state = SWEEP;
            default: next_state = IDLE;
        endcase
    end

    // Issue stage: operands and their golden product are registered together,
    // so the candidate sees cand_a/cand_b one edge after idx selects them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            issue_valid <= 1'b0;
            issue_gold  <= '0;
            cand_a      <= '0;
            cand_b      <= '0;
            drain_cnt   <= '0;
        end else begin
            if (state == SWEEP) begin
                issue_valid <= 1'b1;
                cand_a      <= idx[PW-1:WIDTH];
                cand_b      <= idx[WIDTH-1:0];
                issue_gold  <= PW'(idx[PW-1:WIDTH]) * PW'(idx[WIDTH-1:0]);
                idx         <= idx + PW'(1);
            end else begin
                issue_valid <= 1'b0;
                if (accept) idx <= '0;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
        end
    end

    mult_eval_delay #(
        .LAT (LAT),
        .DW  (DW)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({issue_valid, cand_a, cand_b, issue_gold}),
        .dout  (d_out)
    );

    assign {d_valid, d_a, d_b, d_gold} = d_out;
    assign diff = cand_p ^ d_gold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_count <= '0;
            fail_valid  <= 1'b0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_p      <= '0;
            for (int i = 0; i < PW; i++) be_q[i] <= '0;
        end else if (accept) begin
            match_count <= '0;
            fail_valid  <= 1'b0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_p      <= '0;
            for (int i = 0; i < PW; i++) be_q[i] <= '0;
        end else if (d_valid) begin
            if (diff == '0 && match_count != '1) match_count <= match_count + CW'(1);
            for (int i = 0; i < PW; i++) begin
                if (diff[i] && be_q[i] != '1) be_q[i] <= be_q[i] + CW'(1);
            end
            if (diff != '0 && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_a     <= d_a;
                fail_b     <= d_b;
                fail_p     <= cand_p;
            end
        end
    end

    // done trails entry into DONE by one edge so the last compare has been recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (state == DONE) && !start;
    end

    assign pass = done && (match_count == CW'(N));

    generate
        for (genvar g = 0; g < PW; g++) begin : g_bit_err
            assign bit_err[g*CW +: CW] = be_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_mult_sweep_evaluator.sv
// tb/tb_mult_sweep_evaluator.sv - directed scoreboard bench for mult_sweep_evaluator
module tb_mult_sweep_evaluator;
    import mult_eval_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int PW = DEF_PW;
    localparam int CW = DEF_CW;
    localparam int N  = n_of(DEF_WIDTH);

    typedef struct {
        stat_rec_t rec;
        bit        full;
        bit        pass;
        int        edges;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    int   mode;
    bit   sel;

    logic [W-1:0]     a0, b0, a1, b1, fa0, fb0, fa1, fb1;
    logic [PW-1:0]    p0, p1, fp0, fp1, preg0, preg1;
    logic             busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
    logic [CW-1:0]    mc0, mc1;
    logic [PW*CW-1:0] be0, be1;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mult_sweep_evaluator #(.WIDTH(W), .LAT(0), .CW(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cand_a(a0), .cand_b(b0), .cand_p(p0),
        .busy(busy0), .done(done0), .pass(pass0), .match_count(mc0), .bit_err(be0),
        .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_p(fp0));

    mult_sweep_evaluator #(.WIDTH(W), .LAT(1), .CW(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cand_a(a1), .cand_b(b1), .cand_p(p1),
        .busy(busy1), .done(done1), .pass(pass1), .match_count(mc1), .bit_err(be1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_p(fp1));

    always @(posedge clk) begin
        preg0 <= {2'b00, a0} * {2'b00, b0};
        preg1 <= {2'b00, a1} * {2'b00, b1};
    end

    always_comb begin
        p0 = preg0;
        if (mode == 0)      p0 = {2'b00, a0} * {2'b00, b0};
        else if (mode == 1) p0 = '0;
    end
    assign p1 = preg1;

    wire             o_done = sel ? done1 : done0;
    wire             o_busy = sel ? busy1 : busy0;
    wire             o_pass = sel ? pass1 : pass0;
    wire [CW-1:0]    o_mc   = sel ? mc1 : mc0;
    wire [PW*CW-1:0] o_be   = sel ? be1 : be0;
    wire             o_fv   = sel ? fv1 : fv0;
    wire [W-1:0]     o_fa   = sel ? fa1 : fa0;
    wire [W-1:0]     o_fb   = sel ? fb1 : fb0;
    wire [PW-1:0]    o_fp   = sel ? fp1 : fp0;
    wire [W-1:0]     o_a    = sel ? a1 : a0;
    wire [W-1:0]     o_b    = sel ? b1 : b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // m: 0 exact, 1 tied-zero, 2 one-cycle-late product (only pass is predicted)
    function automatic exp_t model(input bit which, input int m);
        exp_t e;
        logic [PW-1:0] g, c, d;
        e.rec   = '0;
        e.full  = (m != 2);
        e.edges = N + (which ? 1 : 0) + 1;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                g = PW'(a * b);
                c = (m == 1) ? '0 : g;
                d = g ^ c;
                if (d == '0) e.rec.match_count += 1;
                for (int i = 0; i < PW; i++)
                    if (d[i]) e.rec.bit_err[i] += 1;
                if (d != '0 && !e.rec.fail_valid) begin
                    e.rec.fail_valid = 1'b1;
                    e.rec.fail_a     = W'(a);
                    e.rec.fail_b     = W'(b);
                    e.rec.fail_p     = c;
                end
            end
        end
        e.pass = (m != 2) && (e.rec.match_count == CW'(N));
        return e;
    endfunction

    task automatic run_sweep(input bit which, input int m, input int extra_at, input string name);
        exp_t e;
        int   edges;
        bit   got;
        sel  = which;
        mode = (which == 1'b0) ? m : 0;
        sb.push_back(model(which, m));
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (o_done) got = 1'b1;
            start0 = (!which && edges == extra_at);
            start1 = ( which && edges == extra_at);
        end
        start0 = 1'b0;
        start1 = 1'b0;
        e = sb.pop_front();
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_edges"}, edges, e.edges);
        chk({name, "_pass"}, 32'(o_pass), 32'(e.pass));
        if (e.full) begin
            chk({name, "_match"}, 32'(o_mc), 32'(e.rec.match_count));
            for (int i = 0; i < PW; i++)
                chk($sformatf("%s_bit_err%0d", name, i), 32'(o_be[i*CW +: CW]), 32'(e.rec.bit_err[i]));
            chk({name, "_fail_valid"}, 32'(o_fv), 32'(e.rec.fail_valid));
            chk({name, "_fail_a"}, 32'(o_fa), 32'(e.rec.fail_a));
            chk({name, "_fail_b"}, 32'(o_fb), 32'(e.rec.fail_b));
            chk({name, "_fail_p"}, 32'(o_fp), 32'(e.rec.fail_p));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        sel    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done",  32'(done0), 32'd0);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_match", 32'(mc0),   32'd0);
        chk("rst_fv",    32'(fv0),   32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(1'b0, 0, 0, "exact");
        run_sweep(1'b0, 1, 0, "tied0");
        run_sweep(1'b0, 0, 0, "b2b_exact");
        run_sweep(1'b1, 0, 0, "lat1");
        run_sweep(1'b0, 2, 0, "late_on_lat0");
        run_sweep(1'b0, 0, 5, "restart_ignored");

        // Mid-sweep asynchronous reset after partial statistics have built up.
        sel  = 1'b0;
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done",  32'(o_done), 32'd0);
        chk("mid_rst_busy",  32'(o_busy), 32'd0);
        chk("mid_rst_pass",  32'(o_pass), 32'd0);
        chk("mid_rst_match", 32'(o_mc),   32'd0);
        chk("mid_rst_be",    32'(o_be),   32'd0);
        chk("mid_rst_fv",    32'(o_fv),   32'd0);
        chk("mid_rst_a",     32'(o_a),    32'd0);
        chk("mid_rst_b",     32'(o_b),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", 32'(o_busy), 32'd0);
        chk("post_rst_idle_done", 32'(o_done), 32'd0);

        run_sweep(1'b0, 0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_sweep_evaluator.md
Name: mult_sweep_evaluator

Overview:
- Sequential scoring stage wrapped around one generated candidate multiplier (combinational, or pipelined by LAT cycles).
- Drives every operand pair (A,B) into the candidate and consumes its product P.
- Compares P against the golden A*B and accumulates match and per-bit error statistics.
- The statistics feed the reward/fitness computation for the search loop.
- Exhaustive sweep: 2^(2*WIDTH) pairs per run, start/done handshake.

Parameters:
- WIDTH, 2, operand bit-width of A and B; product width PW = 2*WIDTH.
- LAT, 0, candidate pipeline latency in cycles (0 = purely combinational).
- CW, 2*WIDTH+1, counter width; holds values up to 2^(2*WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- cand_a  out  WIDTH  registered operand A to the candidate.
- cand_b  out  WIDTH  registered operand B to the candidate.
- cand_p  in  PW  candidate product.
- busy  out  1  high in SWEEP or DRAIN.
- done  out  1  high in DONE; held until the next accepted start.
- pass  out  1  valid with done: match_count == 2^(2*WIDTH).
- match_count  out  CW  number of pairs with cand_p == A*B.
- bit_err  out  PW*CW  flattened per-product-bit mismatch counters; bit i occupies [i*CW +: CW].
- fail_valid  out  1  at least one mismatch has been captured.
- fail_a, fail_b  out  WIDTH each  operands of the first mismatch.
- fail_p  out  PW  candidate product at the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs, counters, the index and the delay line clear to 0 immediately.
  - This applies at any point, including mid-sweep. Recovery needs a new start.
- States and transitions:
  - IDLE: start -> SWEEP; the index and all statistics clear on this edge.
  - SWEEP: index idx runs 0..N-1 (N = 2^(2*WIDTH)).
    - cand_a = idx[2W-1:W], cand_b = idx[W-1:0], both driven from registers.
    - idx increments every cycle. At idx == N-1, go to DRAIN if LAT>0, else DONE.
  - DRAIN: wait LAT cycles for in-flight results, then go to DONE.
  - DONE: done=1. start -> SWEEP (statistics clear, restart).
- start is ignored while busy.
- Compare timing:
  - Golden product A*B (PW bits, no truncation) and the operands enter a LAT-deep valid-tagged delay line.
  - cand_p is compared in the cycle the tagged entry emerges. With LAT=0 this is the same cycle cand_a/cand_b are presented.
  - Statistics update on the following edge.
- Per compared entry:
  - match_count increments if cand_p equals the golden product.
  - bit_err[i] increments where the two differ in bit i.
  - On the first mismatch only, fail_valid is set and fail_a/fail_b/fail_p are captured.
- Counters saturate at 2^CW-1. They cannot actually reach that value with the default CW.
- Latency: done rises N+LAT+1 rising edges after the edge that samples start.
- pass and the counters are stable and valid whenever done=1. Before that they are partial values.

Decomposition:
- Shared package mult_eval_pkg holds:
  - the state enum (IDLE, SWEEP, DRAIN, DONE);
  - the localparam functions for N and PW;
  - a stat-record typedef {match_count, bit_err array, fail fields}.
- One sub-module, mult_eval_delay: LAT-deep shift register carrying {valid, a, b, golden}. At LAT=0 it is a pass-through.

Test Plan:
- Exact combinational multiplier, WIDTH=2, LAT=0, pulse start:
  - done after 17 edges.
  - match_count=16, pass=1, all bit_err=0, fail_valid=0.
- Candidate tied cand_p=0:
  - match_count=7.
  - bit_err[0]=4, bit_err[1]=6, bit_err[2]=3, bit_err[3]=1.
  - fail_a=1, fail_b=1, fail_p=0, pass=0.
- Exact multiplier with one output register, LAT=1:
  - done after 18 edges, match_count=16.
  - Same DUT with LAT=0 gives pass=0.
- start pulsed again at cycle 5 of SWEEP:
  - Ignored: idx continues and results are identical to the first test.
- rst_n low at cycle 8 of SWEEP:
  - All outputs 0 asynchronously, state IDLE.
  - After release plus start, a full clean sweep produces match_count=16.
- Back-to-back runs:
  - start in DONE after a tied-0 run, now with the exact DUT.
  - Statistics clear; final match_count=16, fail_valid=0.
